// File: rtl/neighbor_count_serializer.sv
// Serial live-neighbor counter for one cell per transaction: shifts the neighbor
// bits out LSB first, accumulates the count and registers the Life next-state bit.
module neighbor_count_serializer #(
    parameter int N_NEIGHBORS = 8,
    parameter int COUNT_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_NEIGHBORS-1:0] neighbors,
    input  logic                   alive,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_W-1:0]     count,
    output logic                   next_alive,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds its data until then, ready never depends on valid.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_NEIGHBORS-1:0] r_sh;
    logic [COUNT_W-1:0]     r_idx;
    logic [COUNT_W-1:0]     r_count;
    logic                   r_alive;
    logic                   r_next_alive;
    logic                   w_accept;
    logic                   w_last;
    logic [COUNT_W-1:0]     w_sum;
    logic                   w_rule;

    assign w_last = (r_idx == COUNT_W'(N_NEIGHBORS - 1));
    assign w_sum  = r_count + COUNT_W'(r_sh[0]);
    // Compared at 32 bits so the constants 2 and 3 survive narrow COUNT_W.
    assign w_rule = (32'(w_sum) == 32'd3) | (r_alive & (32'(w_sum) == 32'd2));

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh         <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_alive      <= 1'b0;
            r_next_alive <= 1'b0;
        end else if (w_accept) begin
            r_sh    <= neighbors;
            r_alive <= alive;
            r_count <= '0;
            r_idx   <= '0;
        end else if (r_state == S_COUNT) begin
            r_count <= w_sum;
            r_sh    <= r_sh >> 1;
            r_idx   <= r_idx + COUNT_W'(1);
            if (w_last) r_next_alive <= w_rule;
        end
    end

    assign count      = r_count;
    assign next_alive = r_next_alive;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_neighbor_count_serializer.sv
// Bench for neighbor_count_serializer: directed rule, backpressure, reset and
// back-to-back cases plus random cells, checked through an expected-result queue.
module tb_neighbor_count_serializer;

    localparam int N   = 8;
    localparam int CW  = 4;
    localparam int LAT = N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  neighbors = '0;
    logic          alive = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          next_alive;
    logic          busy;
    logic [1:0]    state_dbg;

    neighbor_count_serializer #(.N_NEIGHBORS(N), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .neighbors(neighbors), .alive(alive), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .next_alive(next_alive),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW:0]   exp_q[$];
    int            acc_last = 0;
    int            acc_prev = 0;
    int            n_acc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW:0] model(input logic [N-1:0] nb, input logic al);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(nb[i]);
        return {CW'(s), (s == 3) || (al && s == 2)};
    endfunction

    // Monitor: inputs are stable at the falling edge, so what is seen there is
    // what the next rising edge will act on.
    initial begin
        logic [CW:0] e;
        logic        prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                prev_ov = 1'b0;
            end else begin
                check("ready_valid_excl", 32'(in_ready & out_valid), 0);
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(neighbors, alive));
                    acc_prev = acc_last;
                    acc_last = cyc + 1;
                    n_acc++;
                end
                if (out_valid && !prev_ov) check("latency", cyc - acc_last, LAT);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("count", 32'(count), 32'(e[CW:1]));
                        check("next_alive", 32'(next_alive), 32'(e[0]));
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // Present a cell and hold it until accepted; returns just after that edge.
    task automatic send(input logic [N-1:0] nb, input logic al);
        int t = 0;
        in_valid  = 1'b1;
        neighbors = nb;
        alive     = al;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || !in_ready) check("drain_timeout", 0, 1);
        tick();
    endtask

    task automatic wait_out_valid();
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CW:0] e;
        int          n0;
        int          t;

        do_reset();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_next_alive", 32'(next_alive), 0);
        check("rst_state", 32'(state_dbg), 0);
        tick();

        // Live cell with three neighbours survives; out_ready high early.
        out_ready = 1'b1;
        send(8'b0000_0111, 1'b1);
        @(negedge clk);
        check("t1_in_ready_low", 32'(in_ready), 0);
        check("t1_busy", 32'(busy), 1);
        wait_out_valid();
        tick();
        @(negedge clk);
        check("t1_in_ready_after_hs", 32'(in_ready), 1);
        check("t1_out_valid_after_hs", 32'(out_valid), 0);
        tick();

        // Overcrowding, birth, survival with two, no birth with two.
        send(8'hFF, 1'b1);       drain();
        send(8'b1000_0011, 1'b0); drain();
        send(8'b0001_0001, 1'b1); drain();
        send(8'b0001_0001, 1'b0); drain();

        // Backpressure in DONE while upstream keeps offering new cells.
        out_ready = 1'b0;
        e = model(8'b0101_0100, 1'b0);
        send(8'b0101_0100, 1'b0);
        wait_out_valid();
        n0 = n_acc;
        for (int k = 0; k < 5; k++) begin
            tick();
            in_valid  = 1'b1;
            neighbors = N'($urandom_range(0, 255));
            alive     = 1'(k);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_count", 32'(count), 32'(e[CW:1]));
            check("bp_next_alive", 32'(next_alive), 32'(e[0]));
            check("bp_no_accept", n_acc, n0);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_at_release", 32'(out_valid), 1);
        tick();
        @(negedge clk);
        check("bp_idle_after_hs", 32'(in_ready), 1);
        check("bp_queue_empty", exp_q.size(), 0);
        tick();

        // Reset in the 4th COUNT cycle aborts the cell.
        send(8'hFF, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rmc_state", 32'(state_dbg), 0);
        check("rmc_in_ready", 32'(in_ready), 1);
        check("rmc_count", 32'(count), 0);
        check("rmc_next_alive", 32'(next_alive), 0);
        check("rmc_busy", 32'(busy), 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rmc_no_out", 32'(out_valid), 0);
        end
        tick();

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        n0        = n_acc;
        in_valid  = 1'b1;
        neighbors = 8'h0F;
        alive     = 1'b0;
        t         = 0;
        while (n_acc == n0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        tick();
        neighbors = 8'h00;
        t = 0;
        while (n_acc < n0 + 2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("b2b_two_accepts", n_acc - n0, 2);
        check("b2b_interval", acc_last - acc_prev, N + 2);
        tick();
        in_valid = 1'b0;
        drain();

        // Random cells with random downstream stalls.
        for (int k = 0; k < 10; k++) begin
            out_ready = 1'b0;
            send(N'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 12)) tick();
            out_ready = 1'b1;
            drain();
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neighbor_count_serializer.md
# neighbor_count_serializer

Sequential producer for the 4-bit neighbor count consumed by the cell-rule comparators. Accepts one cell's 8 neighbor bits and alive bit per transaction over a valid/ready handshake. Counts live neighbors serially, one bit per cycle, and emits the count plus the Game-of-Life next-state bit over a second valid/ready handshake. It sits between the grid-memory reader and the rule/update stage, and trades area for latency on large grids.

## Interface
- N_NEIGHBORS, default 8. Neighbor bits per cell. Legal range 1..15.
- COUNT_W, default 4. Count width. Must satisfy 2^COUNT_W > N_NEIGHBORS.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  upstream presents a cell.
- in_ready  out  1  block can accept a cell.
- neighbors  in  N_NEIGHBORS  neighbor alive bits; bit 0 is counted first.
- alive  in  1  current state of the cell.
- out_valid  out  1  result is available.
- out_ready  in  1  downstream accepts the result.
- count  out  COUNT_W  number of set bits in the accepted neighbors.
- next_alive  out  1  Life rule result for the accepted cell.
- busy  out  1  high in COUNT and DONE states.

## Operation
- States: IDLE, COUNT, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch neighbors into shift register sh, latch alive into alive_q, clear count to 0, clear idx to 0, go to COUNT.
- **COUNT**
  - in_ready=0, out_valid=0.
  - Each cycle: count <= count + sh[0], sh <= sh>>1, idx <= idx+1.
  - The cycle that adds the last bit (idx==N_NEIGHBORS-1) goes to DONE. next_alive is registered on that same edge from the final sum.
- **DONE**
  - out_valid=1, in_ready=0.
  - count and next_alive are held stable.
  - On out_valid&out_ready: go to IDLE. count and next_alive keep their values until the next acceptance clears count.
- Rule: next_alive = (sum==3) | (alive_q & sum==2). Here sum is the final count.
- Arithmetic: count is unsigned COUNT_W bits and can never overflow, given the parameter constraint.
- Inputs are ignored outside IDLE. in_valid asserted while busy has no effect, and upstream holds its data until in_ready.
- in_valid without in_ready does not latch anything.

## Timing
- Reset (rst=0 at an edge): state=IDLE, count=0, next_alive=0, out_valid=0, busy=0, sh=0, idx=0. in_ready=1 from the first cycle after reset.
- Reset has priority over every other event in every state. A reset in COUNT aborts the transaction, no out_valid is produced, and the cell is lost.
- Acceptance edge E0. COUNT occupies the N_NEIGHBORS edges E1..EN. out_valid is high in the cycle after EN, i.e. N_NEIGHBORS cycles after acceptance.
- Minimum initiation interval is N_NEIGHBORS+2 cycles (10 for the default): one IDLE cycle plus COUNT plus one DONE cycle with out_ready=1.
- out_ready may be high before out_valid. This does not shorten DONE; DONE always lasts at least one cycle.
- out_valid, once high, stays high with stable count and next_alive until the handshake completes.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- **Rule, live cell survives:** after reset, neighbors=8'b0000_0111, alive=1, out_ready=1. Required: in_ready drops after acceptance; out_valid high exactly 8 cycles after acceptance; count=3, next_alive=1; in_ready=1 the cycle after the handshake.
- **Rule, overcrowding and birth:** neighbors=8'hFF, alive=1 -> count=8, next_alive=0. Then neighbors=8'b1000_0011, alive=0 -> count=3, next_alive=1.
- **Rule, survival vs. no birth:** neighbors=8'b0001_0001 with alive=1 -> count=2, next_alive=1. Same neighbors with alive=0 -> count=2, next_alive=0.
- **Backpressure:** out_ready=0 for 5 cycles in DONE, with in_valid=1 and changing neighbors during that time. Required: out_valid, count and next_alive held; in_ready=0; no new cell accepted. Then out_ready=1 -> one handshake, back to IDLE.
- **Reset mid-count:** assert rst=0 in the 4th COUNT cycle. Required: next cycle state IDLE, in_ready=1, count=0, next_alive=0, busy=0; out_valid never asserts for the aborted cell.
- **Back-to-back:** in_valid and out_ready held high with two cells (8'h0F, then 8'h00). Required: the second cell is accepted exactly 10 cycles after the first; results are count=4 / next_alive=0, then count=0 / next_alive=0.
